// File: rtl/lfsr_range_sampler.sv
// lfsr_range_sampler: steps an external LFSR on demand and turns the low
// bits of its state into a uniform value in [0, limit) by mask-and-reject
// sampling. A bounded retry count falls back to a deterministic fold so the
// worst-case latency is fixed. Results leave over a valid/ready handshake.
module lfsr_range_sampler #(
   parameter int NBITS     = 16,
   parameter int OUT_W     = 8,
   parameter int MAX_TRIES = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NBITS-1:0] lfsr_state,
   output logic             lfsr_enable,
   input  logic             req,
   input  logic [OUT_W-1:0] limit,
   output logic             busy,
   output logic             valid,
   input  logic             ready,
   output logic [OUT_W-1:0] value,
   output logic             biased
);

   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_STEP  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [TW-1:0]    tries;
   logic [OUT_W-1:0] lim_q;
   logic [OUT_W-1:0] mask_q;
   logic [OUT_W-1:0] cand;
   logic             cand_ok;
   logic             unused_bits;

   // Smallest all-ones mask covering x: every bit below the MSB is set.
   function automatic logic [OUT_W-1:0] smear(input logic [OUT_W-1:0] x);
      logic [OUT_W-1:0] m;
      m = x;
      for (int i = 1; i < OUT_W; i++) begin
         m = m | (x >> i);
      end
      return m;
   endfunction

   // Only the low OUT_W bits of the LFSR feed the sampler.
   assign unused_bits = ^lfsr_state;

   assign cand    = lfsr_state[OUT_W-1:0] & mask_q;
   assign cand_ok = (lim_q == '0) || (cand < lim_q);

   assign lfsr_enable = (state == S_STEP);
   assign busy        = (state != S_IDLE);
   assign valid       = (state == S_DONE);

   // Sampling FSM: accept request, pulse the LFSR, test the candidate, hold result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         tries  <= '0;
         lim_q  <= '0;
         mask_q <= '0;
         value  <= '0;
         biased <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  lim_q  <= limit;
                  mask_q <= smear(limit - OUT_W'(1));
                  tries  <= '0;
                  state  <= S_STEP;
               end
            end
            S_STEP: begin
               state <= S_CHECK;
            end
            S_CHECK: begin
               if (cand_ok) begin
                  value  <= cand;
                  biased <= 1'b0;
                  state  <= S_DONE;
               end else if (tries == LAST_TRY) begin
                  // mask < 2*lim_q, so a rejected candidate minus lim_q is in range.
                  value  <= cand - lim_q;
                  biased <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  tries <= tries + TW'(1);
                  state <= S_STEP;
               end
            end
            S_DONE: begin
               if (ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Directed testbench for lfsr_range_sampler with a scripted LFSR model.
module tb_lfsr_range_sampler;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] lfsr_state;
   logic        lfsr_enable;
   logic        req;
   logic [7:0]  limit;
   logic        busy;
   logic        valid;
   logic        ready;
   logic [7:0]  value;
   logic        biased;

   // second instance with MAX_TRIES=4 for the fallback path
   logic [15:0] lfsr_state4;
   logic        lfsr_enable4;
   logic        req4;
   logic [7:0]  limit4;
   logic        busy4;
   logic        valid4;
   logic        ready4;
   logic [7:0]  value4;
   logic        biased4;

   logic        load;
   logic [15:0] seq [0:7];
   int          idx;
   int          pulses;
   int          pulses4;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;

   always #5 clk = ~clk;

   lfsr_range_sampler #(.NBITS(16), .OUT_W(8), .MAX_TRIES(15)) dut (
      .clk(clk), .reset(reset), .lfsr_state(lfsr_state), .lfsr_enable(lfsr_enable),
      .req(req), .limit(limit), .busy(busy), .valid(valid), .ready(ready),
      .value(value), .biased(biased)
   );

   lfsr_range_sampler #(.NBITS(16), .OUT_W(8), .MAX_TRIES(4)) dut4 (
      .clk(clk), .reset(reset), .lfsr_state(lfsr_state4), .lfsr_enable(lfsr_enable4),
      .req(req4), .limit(limit4), .busy(busy4), .valid(valid4), .ready(ready4),
      .value(value4), .biased(biased4)
   );

   // Scripted LFSR: seq[0] on load, seq[k] after the k-th enable pulse.
   always @(posedge clk) begin
      if (load) begin
         idx        <= 1;
         pulses     <= 0;
         lfsr_state <= seq[0];
      end else if (lfsr_enable) begin
         lfsr_state <= (idx < 8) ? seq[idx] : 16'h0000;
         idx        <= idx + 1;
         pulses     <= pulses + 1;
      end
   end

   // Enable-pulse counter for the fallback instance.
   always @(posedge clk) begin
      if (load) pulses4 <= 0;
      else if (lfsr_enable4) pulses4 <= pulses4 + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_seq(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
      seq[0] = s0;
      seq[1] = s1;
      seq[2] = s2;
      for (int i = 3; i < 8; i++) seq[i] = 16'h0000;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // Issue one request on dut and count cycles until valid (bounded).
   task automatic run_req(input logic [7:0] lim, output int n);
      limit = lim;
      req   = 1'b1;
      step();
      req = 1'b0;
      n   = 0;
      while (!valid && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic release_result(input string tag);
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk({tag, "_valid_drop"}, valid, 1'b0);
      chk({tag, "_busy_drop"}, busy, 1'b0);
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; limit = 8'd0; ready = 1'b0;
      req4 = 1'b0; limit4 = 8'd0; ready4 = 1'b0; lfsr_state4 = 16'h000F;
      load_seq(16'h0000, 16'h0000, 16'h0000);
      step();
      reset = 1'b0;
      step();

      // reset state
      chk("rst_enable", lfsr_enable, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", valid, 1'b0);
      chk("rst_value", value, 8'h00);
      chk("rst_biased", biased, 1'b0);
      chk("rst_mask", dut.mask_q, 8'h00);
      chk("rst_lim", dut.lim_q, 8'h00);

      // full range: limit=0, state 0x12AB after the pulse
      load_seq(16'h0000, 16'h12AB, 16'h0000);
      limit = 8'd0;
      req   = 1'b1;
      step();
      req = 1'b0;
      chk("full_step_enable", lfsr_enable, 1'b1);
      chk("full_step_busy", busy, 1'b1);
      cyc = 1;
      while (!valid && cyc < 40) begin
         step();
         cyc++;
      end
      chk("full_latency", cyc, 3);
      chk("full_value", value, 8'hAB);
      chk("full_biased", biased, 1'b0);
      chk("full_pulses", pulses, 1);
      chk("full_mask", dut.mask_q, 8'hFF);
      release_result("full");

      // single rejection: 0x0C rejected, 0x07 accepted
      load_seq(16'h0000, 16'h550C, 16'hAA07);
      run_req(8'd10, cyc);
      chk("rej_latency", cyc + 1, 5);
      chk("rej_value", value, 8'd7);
      chk("rej_biased", biased, 1'b0);
      chk("rej_pulses", pulses, 2);
      chk("rej_mask", dut.mask_q, 8'h0F);

      // backpressure: hold ready low while wiggling req and limit
      for (int i = 0; i < 6; i++) begin
         req   = ~req;
         limit = limit + 8'd3;
         step();
         chk("bp_valid", valid, 1'b1);
         chk("bp_value", value, 8'd7);
         chk("bp_busy", busy, 1'b1);
         chk("bp_enable", lfsr_enable, 1'b0);
      end
      req = 1'b0;
      chk("bp_pulses", pulses, 2);
      chk("bp_lim_held", dut.lim_q, 8'd10);
      release_result("bp");

      // fallback on the MAX_TRIES=4 instance: every state ends in 0x0F
      load = 1'b1;
      step();
      load   = 1'b0;
      limit4 = 8'd10;
      req4   = 1'b1;
      step();
      req4 = 1'b0;
      cyc  = 1;
      while (!valid4 && cyc < 60) begin
         step();
         cyc++;
      end
      chk("fb_latency", cyc, 9);
      chk("fb_value", value4, 8'd5);
      chk("fb_biased", biased4, 1'b1);
      chk("fb_pulses", pulses4, 4);
      ready4 = 1'b1;
      step();
      ready4 = 1'b0;
      chk("fb_valid_drop", valid4, 1'b0);
      chk("fb_busy_drop", busy4, 1'b0);

      // reset mid-operation during CHECK
      load_seq(16'h0000, 16'h0003, 16'h0000);
      limit = 8'd10;
      req   = 1'b1;
      step();
      req = 1'b0;
      step();
      chk("mid_in_check", dut.state, 2'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_state", dut.state, 2'd0);
      chk("mid_busy", busy, 1'b0);
      chk("mid_valid", valid, 1'b0);
      chk("mid_value", value, 8'h00);
      chk("mid_biased", biased, 1'b0);
      chk("mid_enable", lfsr_enable, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("mid_no_result", valid, 1'b0);
      end
      chk("mid_pulses", pulses, 1);

      // limit=1: always 0 on first try
      load_seq(16'h0000, 16'hFFFF, 16'h0000);
      run_req(8'd1, cyc);
      chk("lim1_latency", cyc + 1, 3);
      chk("lim1_value", value, 8'h00);
      chk("lim1_mask", dut.mask_q, 8'h00);
      chk("lim1_pulses", pulses, 1);
      release_result("lim1");

      // limit=128 with state 0xFFC3
      load_seq(16'h0000, 16'hFFC3, 16'h0000);
      run_req(8'd128, cyc);
      chk("lim128_latency", cyc + 1, 3);
      chk("lim128_mask", dut.mask_q, 8'h7F);
      chk("lim128_value", value, 8'h43);
      chk("lim128_biased", biased, 1'b0);
      release_result("lim128");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
